shift_sequencer: RTL and testbench
==================================

# shift_sequencer

- Multi-cycle shift controller for the MIPS datapath shifter.
- Selects the shift-amount source by driving the select of the existing 3-input 5-bit shift-amount mux:
  - 0 = instruction shamt
  - 1 = rs[4:0]
  - 2 = constant 16 (LUI)
- Performs sll/srl/sra iteratively on a 32-bit operand.
- Reports completion with a one-cycle done pulse, so the control unit can stall during long shifts.

## Interface
- DATA_W, 32, operand/result width
- AMT_W, 5, shift-amount width; the maximum shift is 2^AMT_W-1
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE or DONE
- op  in  2  00 pass, 01 sll, 10 srl, 11 sra
- amt_src  in  2  00 shamt_in, 01 rs_amt_in, 10 constant 16, 11 illegal
- shamt_in  in  AMT_W  instruction shamt field
- rs_amt_in  in  AMT_W  low bits of rs
- data_in  in  DATA_W  operand
- shamt_sel  out  2  select to the shift-amount mux; latched amt_src; 2'b00 when the source is illegal
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse in DONE
- err  out  1  pulse together with done when amt_src==11
- result  out  DATA_W  shifted value; holds until the next accepted start

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state IDLE, count 0, result 0, shamt_sel 0, busy 0, done 0, err 0.
- Start acceptance (IDLE, or DONE for back-to-back commands), on start=1:
  - latch op, data_in and amt_src
  - load N = selected amount
  - N is forced to 0 when op==00 or amt_src==11
  - next state is SHIFT if N>0, else DONE
- SHIFT, each edge:
  - shift the working register by 1 (sll/srl zero-fill; sra replicates bit DATA_W-1)
  - count decrements
  - leave for DONE when count reaches 0
- DONE:
  - done=1 for exactly one cycle
  - err=1 in the same cycle if the latched amt_src==11
  - go to IDLE, or restart if start=1
- start in SHIFT is ignored; it is not queued.
- The working register is result itself, so result is valid from DONE until the next accepted start.
- A reset assertion mid-shift aborts immediately to the reset values; no done is issued.
- Shift amounts use modulo 2^AMT_W; there is no overflow check.

## Timing
- Start sampled at edge 0. The done cycle follows edge N:
  - N=0: done in the cycle right after edge 0
  - N=31: done after edge 31
- busy is high for N cycles. It is never high when N=0.
- shamt_sel is valid from the cycle after the start edge through DONE.
- Back-to-back: start held high in DONE is accepted on that edge; done is never asserted in two consecutive cycles unless N=0.

## Configuration
- SHIFT_SEQ_STRIDE4_EN
  - Defined: in SHIFT, shift by 4 and decrement count by 4 while count>=4, otherwise by 1. Done follows edge floor(N/4)+(N mod 4).
  - Undefined: stride is always 1, as above.
- Results must be identical with and without the macro.

## Structure
- Shared package shift_seq_pkg:
  - op encodings
  - amt_src encodings: SRC_SHAMT, SRC_RS, SRC_LUI, SRC_BAD
  - LUI_SHAMT=16
  - state enum
- One sub-module, shift_seq_step: combinational single-step shifter taking value, op and k (1 or 4), returning the shifted value.

## Test plan
- Reset during SHIFT:
  - stimulus: sll data 0x00000001 by shamt_in=20; assert reset_n=0 at cycle 5
  - response: all outputs return to 0 asynchronously; no done
- sll via rs:
  - stimulus: data 0x00000001, amt_src=01, rs_amt_in=31
  - response: result 0x80000000; done after edge 31; busy high 31 cycles; shamt_sel=01
- sra via constant:
  - stimulus: data 0x80000000, amt_src=10
  - response: result 0xFFFF8000; done after edge 16; shamt_sel=10
- Zero-amount cases:
  - stimulus: srl with shamt_in=0; separately op=00 with shamt_in=7
  - response: result equals data_in; done in the cycle after start; busy never high
- Illegal source:
  - stimulus: amt_src=11, data 0x1234
  - response: result 0x1234; done=1 and err=1 in the same cycle; shamt_sel=00
- Back-to-back and ignored start:
  - stimulus: srl 0xF0000000 by 4 with start held through DONE, second command srl by 1; also pulse start during SHIFT
  - response: first result 0x0F000000, second command accepted on the DONE edge; the start pulsed during SHIFT has no effect

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: ops, amount sources, FSM states.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_SLL  = 2'b01,
      OP_SRL  = 2'b10,
      OP_SRA  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SRC_SHAMT = 2'b00,
      SRC_RS    = 2'b01,
      SRC_LUI   = 2'b10,
      SRC_BAD   = 2'b11
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam int LUI_SHAMT = 16;

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single-step shifter: shifts value by k (1 or 4) according to op.
module shift_seq_step
   import shift_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] value,
   input  op_e               op,
   input  logic [2:0]        k,
   output logic [DATA_W-1:0] shifted
);

   always_comb begin
      shifted = value;
      case (op)
         OP_SLL:  shifted = value << k;
         OP_SRL:  shifted = value >> k;
         OP_SRA:  shifted = DATA_W'($signed(value) >>> k);
         default: shifted = value;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative sll/srl/sra controller with one-cycle done pulse.
// Optional macro SHIFT_SEQ_STRIDE4_EN: step by 4 while the remaining count is >= 4.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [1:0]        amt_src,
   input  logic [AMT_W-1:0]  shamt_in,
   input  logic [AMT_W-1:0]  rs_amt_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [1:0]        shamt_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result
);

   state_e            state, state_d;
   logic [AMT_W-1:0]  count;
   logic [AMT_W-1:0]  n_ld;
   op_e               op_q;
   src_e              src_q;
   logic              load, shift_en;
   logic [2:0]        k;
   logic [DATA_W-1:0] step_out;

`ifdef SHIFT_SEQ_STRIDE4_EN
   assign k = (count >= AMT_W'(4)) ? 3'd4 : 3'd1;
`else
   assign k = 3'd1;
`endif

   // Amount to load on an accepted start; pass and illegal sources collapse to zero.
   always_comb begin
      n_ld = '0;
      case (src_e'(amt_src))
         SRC_SHAMT: n_ld = shamt_in;
         SRC_RS:    n_ld = rs_amt_in;
         SRC_LUI:   n_ld = AMT_W'(LUI_SHAMT);
         default:   n_ld = '0;
      endcase
      if (op_e'(op) == OP_PASS) n_ld = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d  = state;
      load     = 1'b0;
      shift_en = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         ST_IDLE: load = start;
         ST_SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (count == AMT_W'(k)) state_d = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            err  = (src_q == SRC_BAD);
            if (start) load = 1'b1;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) state_d = (n_ld != '0) ? ST_SHIFT : ST_DONE;
   end

   // result doubles as the working register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result    <= '0;
         count     <= '0;
         op_q      <= OP_PASS;
         src_q     <= SRC_SHAMT;
         shamt_sel <= 2'b00;
      end else if (load) begin
         result    <= data_in;
         count     <= n_ld;
         op_q      <= op_e'(op);
         src_q     <= src_e'(amt_src);
         shamt_sel <= (src_e'(amt_src) == SRC_BAD) ? 2'b00 : amt_src;
      end else if (shift_en) begin
         result <= step_out;
         count  <= count - AMT_W'(k);
      end
   end

   shift_seq_step #(.DATA_W(DATA_W)) u_step (
      .value   (result),
      .op      (op_q),
      .k       (k),
      .shifted (step_out)
   );

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expectations, monitor checks on done.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00, amt_src = 2'b00;
   logic [4:0]  shamt_in = '0, rs_amt_in = '0;
   logic [31:0] data_in = '0;
   logic [1:0]  shamt_sel;
   logic        busy, done, err;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      logic        err;
      logic [1:0]  sel;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0, n_tot = 0;
   int   cyc = 0, busy_cnt = 0;

   shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .amt_src(amt_src),
      .shamt_in(shamt_in), .rs_amt_in(rs_amt_in), .data_in(data_in),
      .shamt_sel(shamt_sel), .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int lat(input int n);
`ifdef SHIFT_SEQ_STRIDE4_EN
      return n / 4 + n % 4;
`else
      return n;
`endif
   endfunction

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (!reset_n) busy_cnt = 0;
      else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("err", 32'(err), 32'(e.err));
               chk("shamt_sel", 32'(shamt_sel), 32'(e.sel));
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
               chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [4:0] sh,
                        input logic [4:0] rs, input logic [31:0] d, input logic [31:0] r,
                        input logic e, input logic [1:0] sel, input int n, input bit hold);
      @(negedge clk);
      op = o; amt_src = s; shamt_in = sh; rs_amt_in = rs; data_in = d; start = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{r, e, sel, lat(n), cyc});
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (sb.size() == 0) return;
      end
      n_tot++;
      $display("FAIL timeout: got %0d pending expected 0", sb.size());
      sb.delete();
   endtask

   initial begin
      #2;
      chk("rst_result", result, 32'h0);
      chk("rst_outs", {28'h0, busy, done, err, |shamt_sel}, 32'h0);
      @(negedge clk); reset_n = 1'b1;

      // op, src, shamt, rs, data, expected, err, sel, N, hold
      issue(2'b01, 2'b01, 5'd0,  5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0, 2'b01, 31, 1'b0); wait_idle();
      issue(2'b11, 2'b10, 5'd3,  5'd9,  32'h8000_0000, 32'hFFFF_8000, 1'b0, 2'b10, 16, 1'b0); wait_idle();
      issue(2'b10, 2'b00, 5'd0,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2'b00, 0,  1'b0); wait_idle();
      issue(2'b00, 2'b00, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 1'b0, 2'b00, 0,  1'b0); wait_idle();
      issue(2'b01, 2'b11, 5'd5,  5'd5,  32'h0000_1234, 32'h0000_1234, 1'b1, 2'b00, 0,  1'b0); wait_idle();
      issue(2'b10, 2'b00, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 31, 1'b0); wait_idle();
      issue(2'b01, 2'b00, 5'd13, 5'd0,  32'h0000_0003, 32'h0000_6000, 1'b0, 2'b00, 13, 1'b0); wait_idle();

      // Back-to-back: start held through SHIFT (ignored) and DONE (accepted).
      issue(2'b10, 2'b00, 5'd4, 5'd0, 32'hF000_0000, 32'h0F00_0000, 1'b0, 2'b00, 4, 1'b1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) break;
      end
      op = 2'b10; amt_src = 2'b00; shamt_in = 5'd1; data_in = 32'h0000_0003;
      @(posedge clk); #1;
      sb.push_back('{32'h0000_0001, 1'b0, 2'b00, lat(1), cyc});
      start = 1'b0;
      wait_idle();

      // Start pulsed mid-shift must be dropped.
      issue(2'b11, 2'b00, 5'd5, 5'd0, 32'h8000_0010, 32'hFC00_0000, 1'b0, 2'b00, 5, 1'b0);
      @(negedge clk); @(negedge clk);
      op = 2'b00; data_in = 32'hDEAD_BEEF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("result_hold", result, 32'hFC00_0000);
      chk("idle_after_ignored", {30'h0, busy, done}, 32'h0);

      // Reset mid-shift aborts with no done.
      issue(2'b01, 2'b00, 5'd20, 5'd0, 32'h0000_0001, 32'h0010_0000, 1'b0, 2'b00, 20, 1'b0);
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_result", result, 32'h0);
      chk("abort_outs", {28'h0, busy, done, err, |shamt_sel}, 32'h0);
      sb.delete();
      @(negedge clk); @(negedge clk); reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("idle_after_reset", {29'h0, busy, done, err}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
